posit_add_issuer: RTL and testbench

POSIT_ADD_ISSUER -- requirements
Module: posit_add_issuer

---
 rtl/posit_add_issuer.sv | 175 +++++++++++++++++
 tb/tb_posit_add_issuer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_add_issuer.sv
// Posit adder issue/collect wrapper: credit-limited operand issue, in-order result FIFO.
// Latency: add_start 1 cycle after acceptance, res_valid 1 cycle after add_done; backpressure via op_ready credits and res_ready.
// Optional POSIT_ADD_ISSUER_STATS_EN adds issued_cnt/completed_cnt.
module posit_add_issuer #(
    parameter int N     = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    output logic         add_start,
    output logic [N-1:0] add_in1,
    output logic [N-1:0] add_in2,
    input  logic         add_done,
    input  logic [N-1:0] add_result,
    input  logic         add_inf,
    input  logic         add_zero,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic         res_inf,
    output logic         res_zero,
    output logic         busy,
    output logic         err
`ifdef POSIT_ADD_ISSUER_STATS_EN
    ,
    output logic [31:0]  issued_cnt,
    output logic [31:0]  completed_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FULL} state_t;

    state_t          r_state;
    logic            r_busy;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_rd_ptr;
    logic            r_err;
    logic            r_add_start;
    logic [N-1:0]    r_add_in1;
    logic [N-1:0]    r_add_in2;
    logic [N+1:0]    r_mem [DEPTH];

    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_total;
    logic [CW-1:0]   w_inflight_nxt;
    logic [CW-1:0]   w_count_nxt;
    logic [CW-1:0]   w_total_nxt;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic [N+1:0]    w_head;

    // Pointers carry a wrap bit so full and empty are distinguishable.
    assign w_count        = r_wr_ptr - r_rd_ptr;
    assign w_total        = r_inflight + w_count;
    assign w_empty        = (w_count == '0);
    assign op_ready       = (w_total < L_DEPTH);
    assign w_accept       = op_valid & op_ready;
    assign w_push         = add_done & (r_inflight != '0);
    assign w_pop          = res_valid & res_ready;
    assign w_inflight_nxt = r_inflight + CW'(w_accept) - CW'(w_push);
    assign w_count_nxt    = w_count + CW'(w_push) - CW'(w_pop);
    assign w_total_nxt    = w_inflight_nxt + w_count_nxt;

    assign w_head    = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign res_valid = ~w_empty;
    assign res_data  = w_head[N+1:2];
    assign res_inf   = w_head[1];
    assign res_zero  = w_head[0];

    assign add_start = r_add_start;
    assign add_in1   = r_add_in1;
    assign add_in2   = r_add_in2;
    assign busy      = r_busy;
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_err       <= 1'b0;
            r_add_start <= 1'b0;
            r_add_in1   <= '0;
            r_add_in2   <= '0;
        end else begin
            r_inflight  <= w_inflight_nxt;
            r_add_start <= w_accept;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + CW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + CW'(1);
            end
            // A completion with nothing outstanding is dropped and latched as an error.
            if (add_done && (r_inflight == '0)) begin
                r_err <= 1'b1;
            end
            if (w_accept) begin
                r_add_in1 <= op_a;
                r_add_in2 <= op_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {add_result, add_inf, add_zero};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_ACTIVE;
                        r_busy  <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (w_total_nxt == L_DEPTH) begin
                        r_state <= S_FULL;
                    end else if (w_total_nxt == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        r_state <= S_ACTIVE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef POSIT_ADD_ISSUER_STATS_EN
    logic [31:0] r_issued_cnt;
    logic [31:0] r_completed_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_issued_cnt    <= '0;
            r_completed_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_issued_cnt <= r_issued_cnt + 32'd1;
            end
            if (w_pop) begin
                r_completed_cnt <= r_completed_cnt + 32'd1;
            end
        end
    end

    assign issued_cnt    = r_issued_cnt;
    assign completed_cnt = r_completed_cnt;
`endif
endmodule

// File: tb/tb_posit_add_issuer.sv
// Bench for posit_add_issuer: latency-4 adder model, outstanding-count and in-order result scoreboard.
module tb_posit_add_issuer;
    localparam int N     = 32;
    localparam int DEPTH = 8;
    localparam logic [31:0] NAR = 32'h8000_0000;

    logic          clk;
    logic          reset;
    logic          op_valid;
    logic          op_ready;
    logic [N-1:0]  op_a;
    logic [N-1:0]  op_b;
    logic          add_start;
    logic [N-1:0]  add_in1;
    logic [N-1:0]  add_in2;
    logic          add_done;
    logic [N-1:0]  add_result;
    logic          add_inf;
    logic          add_zero;
    logic          res_valid;
    logic          res_ready;
    logic [N-1:0]  res_data;
    logic          res_inf;
    logic          res_zero;
    logic          busy;
    logic          err;
`ifdef POSIT_ADD_ISSUER_STATS_EN
    logic [31:0]   issued_cnt;
    logic [31:0]   completed_cnt;
`endif

    logic          model_done;
    logic          stray_done;
    assign add_done = model_done | stray_done;

    posit_add_issuer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .add_start(add_start), .add_in1(add_in1), .add_in2(add_in2),
        .add_done(add_done), .add_result(add_result), .add_inf(add_inf), .add_zero(add_zero),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_inf(res_inf), .res_zero(res_zero), .busy(busy), .err(err)
`ifdef POSIT_ADD_ISSUER_STATS_EN
        , .issued_cnt(issued_cnt), .completed_cnt(completed_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Stand-in adder arithmetic: modular sum, NaR propagates as infinity.
    function automatic logic [33:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        logic        inf;
        s   = a + b;
        inf = (a == NAR) || (b == NAR);
        return {inf ? NAR : s, inf, (!inf && s == 32'd0)};
    endfunction

    typedef struct {
        int          due;
        logic [31:0] a;
        logic [31:0] b;
    } job_t;

    job_t         mq[$];
    logic [33:0]  exp_q[$];
    int           outstanding = 0;
    int           n_acc = 0;
    int           n_pop = 0;
    int           cyc = 0;
    logic         pend_issue = 1'b0;
    logic [31:0]  pend_a;
    logic [31:0]  pend_b;

    // Adder model: completes each started operation exactly 4 cycles later, in order.
    initial begin
        model_done = 1'b0;
        add_result = '0;
        add_inf    = 1'b0;
        add_zero   = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (reset) begin
                mq.delete();
                model_done = 1'b0;
                pend_issue = 1'b0;
            end else begin
                check("add_start", {63'd0, add_start}, {63'd0, pend_issue});
                if (add_start && pend_issue) begin
                    check("add_in1", {32'd0, add_in1}, {32'd0, pend_a});
                    check("add_in2", {32'd0, add_in2}, {32'd0, pend_b});
                end
                pend_issue = 1'b0;
                model_done = 1'b0;
                if (mq.size() > 0 && mq[0].due == cyc) begin
                    {add_result, add_inf, add_zero} = fadd(mq[0].a, mq[0].b);
                    model_done = 1'b1;
                    void'(mq.pop_front());
                end
                if (add_start) begin
                    mq.push_back('{due: cyc + 4, a: add_in1, b: add_in2});
                end
            end
        end
    end

    // One cycle at the negedge: check credit/busy, record handshakes, advance.
    task automatic tick();
        if (!reset) begin
            check("op_ready", {63'd0, op_ready}, {63'd0, (outstanding < DEPTH)});
            check("busy", {63'd0, busy}, {63'd0, (outstanding != 0)});
            if (op_valid && op_ready) begin
                exp_q.push_back(fadd(op_a, op_b));
                pend_issue = 1'b1;
                pend_a     = op_a;
                pend_b     = op_b;
                outstanding++;
                n_acc++;
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {63'd0, res_valid}, 64'd0);
                end else begin
                    check("result", {30'd0, res_data, res_inf, res_zero}, {30'd0, exp_q[0]});
                    void'(exp_q.pop_front());
                end
                outstanding--;
                n_pop++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        op_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        outstanding = 0;
    endtask

    task automatic drain();
        op_valid  = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 200 && outstanding != 0; i++) tick();
        check("drain_outstanding", 64'(outstanding), 64'd0);
        res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int base;
        reset      = 1'b1;
        op_valid   = 1'b0;
        op_a       = '0;
        op_b       = '0;
        res_ready  = 1'b0;
        stray_done = 1'b0;
        @(negedge clk);
        tick();
        tick();
        check("rst_op_ready", {63'd0, op_ready}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("rst_add_start", {63'd0, add_start}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_add_in1", {32'd0, add_in1}, 64'd0);
        check("rst_add_in2", {32'd0, add_in2}, 64'd0);
        check("rst_res_data", {32'd0, res_data}, 64'd0);
        reset = 1'b0;

        // Single operation and its latency.
        op_valid = 1'b1;
        op_a     = 32'hADB9_4A07;
        op_b     = 32'h1E7C_9864;
        tick();
        op_valid = 1'b0;
        check("single_add_start", {63'd0, add_start}, 64'd1);
        check("single_add_in1", {32'd0, add_in1}, 64'hADB9_4A07);
        k = 1;
        while (!res_valid && k < 20) begin
            tick();
            k++;
        end
        check("single_latency", 64'(k), 64'd6);
        check("single_data", {32'd0, res_data}, {32'd0, 32'hADB9_4A07 + 32'h1E7C_9864});
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();

        // Fill to DEPTH with the result stream stalled.
        base     = n_acc;
        op_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            op_a = $urandom;
            op_b = ($urandom_range(0, 7) == 0) ? NAR : $urandom;
            tick();
        end
        op_valid = 1'b0;
        check("full_accepted", 64'(n_acc - base), 64'd8);
        check("full_op_ready", {63'd0, op_ready}, 64'd0);
        check("full_busy", {63'd0, busy}, 64'd1);
        check("full_res_valid", {63'd0, res_valid}, 64'd1);
        tick();
        check("full_stable_data", {30'd0, res_data, res_inf, res_zero}, {30'd0, exp_q[0]});
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("pop_op_ready", {63'd0, op_ready}, 64'd1);
        drain();

        // Completion with nothing outstanding.
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        tick();
        check("stray_err", {63'd0, err}, 64'd1);
        check("stray_res_valid", {63'd0, res_valid}, 64'd0);
        for (int i = 0; i < 5; i++) tick();
        check("stray_err_held", {63'd0, err}, 64'd1);
        do_reset();
        check("stray_err_cleared", {63'd0, err}, 64'd0);

        // Back-to-back with free-running results: accept and done coincide.
        base      = n_acc;
        op_valid  = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            op_a = $urandom;
            op_b = $urandom;
            tick();
        end
        check("b2b_accepted", 64'(n_acc - base), 64'd12);

        // Random valid/ready traffic, 20 ops across pointer wrap.
        base = n_acc;
        for (int i = 0; i < 400 && (n_acc - base) < 20; i++) begin
            op_valid  = ($urandom_range(0, 3) != 0);
            op_a      = $urandom;
            op_b      = ($urandom_range(0, 9) == 0) ? NAR : $urandom;
            res_ready = $urandom_range(0, 1);
            tick();
        end
        check("rand_accepted", 64'(n_acc - base), 64'd20);
        drain();
        check("rand_err", {63'd0, err}, 64'd0);
        check("rand_busy", {63'd0, busy}, 64'd0);

        // Reset with three in flight and two buffered.
        res_ready = 1'b0;
        op_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            op_a = $urandom;
            op_b = $urandom;
            tick();
        end
        op_valid = 1'b0;
        tick();
        tick();
        check("pre_rst_res_valid", {63'd0, res_valid}, 64'd1);
        check("pre_rst_outstanding", 64'(outstanding), 64'd5);
`ifdef POSIT_ADD_ISSUER_STATS_EN
        check("pre_rst_issued", {32'd0, issued_cnt}, 64'(n_acc));
`endif
        reset = 1'b1;
        tick();
        check("mid_rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_op_ready", {63'd0, op_ready}, 64'd1);
`ifdef POSIT_ADD_ISSUER_STATS_EN
        check("mid_rst_issued", {32'd0, issued_cnt}, 64'd0);
        check("mid_rst_completed", {32'd0, completed_cnt}, 64'd0);
`endif
        reset = 1'b0;
        exp_q.delete();
        outstanding = 0;
        for (int i = 0; i < 8; i++) tick();
        check("post_rst_err", {63'd0, err}, 64'd0);
        check("post_rst_res_valid", {63'd0, res_valid}, 64'd0);

        // Recovery after reset.
        op_valid = 1'b1;
        op_a     = 32'h4000_0000;
        op_b     = 32'hC000_0000;
        tick();
        op_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
